// File: rtl/axi_lite_arb_pkg.sv
// Shared types and constants for the two-to-one AXI4-Lite arbiter.
package axi_lite_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_WR_RET  = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_RESP = 3'd5,
        ST_RD_RET  = 3'd6
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic req_idx_t;

    function automatic logic [1:0] req_onehot(input req_idx_t idx);
        logic [1:0] oh;
        if (idx == 1'b1) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/axi_lite_arb_rr2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to ptr.
module axi_lite_arb_rr2
    import axi_lite_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   ptr,
    output logic       gnt_valid,
    output req_idx_t   gnt_idx
);

    // Resolve the winner from the request pair and the fairness pointer
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
        case (req)
            2'b01: begin
                gnt_valid = 1'b1;
                gnt_idx   = 1'b0;
            end
            2'b10: begin
                gnt_valid = 1'b1;
                gnt_idx   = 1'b1;
            end
            2'b11: begin
                gnt_valid = 1'b1;
                gnt_idx   = ptr;
            end
            default: begin
                gnt_valid = 1'b0;
                gnt_idx   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/axi_lite_arb_2to1.sv
// Store-and-forward 2:1 AXI4-Lite arbiter; one transaction in flight,
// round-robin between requesters, response routed back only to the winner.
module axi_lite_arb_2to1
    import axi_lite_arb_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [2*C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [5:0]                        S_AXI_AWPROT,
    input  logic [1:0]                        S_AXI_AWVALID,
    output logic [1:0]                        S_AXI_AWREADY,
    input  logic [2*C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [2*C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic [1:0]                        S_AXI_WVALID,
    output logic [1:0]                        S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic [1:0]                        S_AXI_BVALID,
    input  logic [1:0]                        S_AXI_BREADY,
    input  logic [2*C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [5:0]                        S_AXI_ARPROT,
    input  logic [1:0]                        S_AXI_ARVALID,
    output logic [1:0]                        S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic [1:0]                        S_AXI_RVALID,
    input  logic [1:0]                        S_AXI_RREADY,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    arb_state_e     state_r;
    req_idx_t       rr_ptr_r;
    req_idx_t       gnt_r;
    logic           aw_done_r;
    logic           w_done_r;

    logic [1:0]     s_awready_r;
    logic [1:0]     s_wready_r;
    logic [1:0]     s_arready_r;
    logic [1:0]     s_bvalid_r;
    logic [1:0]     s_rvalid_r;
    logic [1:0]     s_bresp_r;
    logic [1:0]     s_rresp_r;
    logic [DW-1:0]  s_rdata_r;
    logic [AW-1:0]  m_awaddr_r;
    logic [2:0]     m_awprot_r;
    logic           m_awvalid_r;
    logic [DW-1:0]  m_wdata_r;
    logic [SW-1:0]  m_wstrb_r;
    logic           m_wvalid_r;
    logic           m_bready_r;
    logic [AW-1:0]  m_araddr_r;
    logic [2:0]     m_arprot_r;
    logic           m_arvalid_r;
    logic           m_rready_r;

    logic [1:0]     wr_req_s;
    logic [1:0]     any_req_s;
    logic           gnt_valid_s;
    req_idx_t       gnt_idx_s;
    logic           sel_wr_s;
    logic [AW-1:0]  sel_awaddr_s;
    logic [2:0]     sel_awprot_s;
    logic [DW-1:0]  sel_wdata_s;
    logic [SW-1:0]  sel_wstrb_s;
    logic [AW-1:0]  sel_araddr_s;
    logic [2:0]     sel_arprot_s;
    logic           aw_ok_s;
    logic           w_ok_s;

    assign wr_req_s  = S_AXI_AWVALID & S_AXI_WVALID;
    assign any_req_s = wr_req_s | S_AXI_ARVALID;
    assign aw_ok_s   = aw_done_r | (m_awvalid_r & M_AXI_AWREADY);
    assign w_ok_s    = w_done_r  | (m_wvalid_r  & M_AXI_WREADY);

    axi_lite_arb_rr2 u_rr2 (
        .req       (any_req_s),
        .ptr       (rr_ptr_r),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    // Route the candidate winner's request fields toward the capture registers
    always_comb begin
        if (gnt_idx_s == 1'b1) begin
            sel_awaddr_s = S_AXI_AWADDR[2*AW-1:AW];
            sel_awprot_s = S_AXI_AWPROT[5:3];
            sel_wdata_s  = S_AXI_WDATA[2*DW-1:DW];
            sel_wstrb_s  = S_AXI_WSTRB[2*SW-1:SW];
            sel_araddr_s = S_AXI_ARADDR[2*AW-1:AW];
            sel_arprot_s = S_AXI_ARPROT[5:3];
        end else begin
            sel_awaddr_s = S_AXI_AWADDR[AW-1:0];
            sel_awprot_s = S_AXI_AWPROT[2:0];
            sel_wdata_s  = S_AXI_WDATA[DW-1:0];
            sel_wstrb_s  = S_AXI_WSTRB[SW-1:0];
            sel_araddr_s = S_AXI_ARADDR[AW-1:0];
            sel_arprot_s = S_AXI_ARPROT[2:0];
        end
        sel_wr_s = wr_req_s[gnt_idx_s];
    end

    // Transaction FSM; every port-facing signal is a register updated here
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= 1'b0;
            gnt_r       <= 1'b0;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            s_awready_r <= 2'b00;
            s_wready_r  <= 2'b00;
            s_arready_r <= 2'b00;
            s_bvalid_r  <= 2'b00;
            s_rvalid_r  <= 2'b00;
            s_bresp_r   <= RESP_OKAY;
            s_rresp_r   <= RESP_OKAY;
            s_rdata_r   <= '0;
            m_awaddr_r  <= '0;
            m_awprot_r  <= 3'b000;
            m_awvalid_r <= 1'b0;
            m_wdata_r   <= '0;
            m_wstrb_r   <= '0;
            m_wvalid_r  <= 1'b0;
            m_bready_r  <= 1'b0;
            m_araddr_r  <= '0;
            m_arprot_r  <= 3'b000;
            m_arvalid_r <= 1'b0;
            m_rready_r  <= 1'b0;
        end else begin
            // Slave-side readies are single-cycle pulses issued only from IDLE
            s_awready_r <= 2'b00;
            s_wready_r  <= 2'b00;
            s_arready_r <= 2'b00;
            case (state_r)
                ST_IDLE: begin
                    if (gnt_valid_s) begin
                        gnt_r <= gnt_idx_s;
                        if (sel_wr_s) begin
                            m_awaddr_r  <= sel_awaddr_s;
                            m_awprot_r  <= sel_awprot_s;
                            m_wdata_r   <= sel_wdata_s;
                            m_wstrb_r   <= sel_wstrb_s;
                            m_awvalid_r <= 1'b1;
                            m_wvalid_r  <= 1'b1;
                            aw_done_r   <= 1'b0;
                            w_done_r    <= 1'b0;
                            s_awready_r <= req_onehot(gnt_idx_s);
                            s_wready_r  <= req_onehot(gnt_idx_s);
                            state_r     <= ST_WR_REQ;
                        end else begin
                            m_araddr_r  <= sel_araddr_s;
                            m_arprot_r  <= sel_arprot_s;
                            m_arvalid_r <= 1'b1;
                            s_arready_r <= req_onehot(gnt_idx_s);
                            state_r     <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (m_awvalid_r && M_AXI_AWREADY) begin
                        m_awvalid_r <= 1'b0;
                        aw_done_r   <= 1'b1;
                    end
                    if (m_wvalid_r && M_AXI_WREADY) begin
                        m_wvalid_r <= 1'b0;
                        w_done_r   <= 1'b1;
                    end
                    if (aw_ok_s && w_ok_s) begin
                        m_bready_r <= 1'b1;
                        state_r    <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        s_bresp_r  <= M_AXI_BRESP;
                        m_bready_r <= 1'b0;
                        s_bvalid_r <= req_onehot(gnt_r);
                        state_r    <= ST_WR_RET;
                    end
                end
                ST_WR_RET: begin
                    if (S_AXI_BREADY[gnt_r]) begin
                        s_bvalid_r <= 2'b00;
                        rr_ptr_r   <= ~gnt_r;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    if (M_AXI_ARREADY) begin
                        m_arvalid_r <= 1'b0;
                        m_rready_r  <= 1'b1;
                        state_r     <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        s_rdata_r  <= M_AXI_RDATA;
                        s_rresp_r  <= M_AXI_RRESP;
                        m_rready_r <= 1'b0;
                        s_rvalid_r <= req_onehot(gnt_r);
                        state_r    <= ST_RD_RET;
                    end
                end
                ST_RD_RET: begin
                    if (S_AXI_RREADY[gnt_r]) begin
                        s_rvalid_r <= 2'b00;
                        rr_ptr_r   <= ~gnt_r;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    // Unreachable encoding: drop everything in flight and re-arbitrate
                    m_awvalid_r <= 1'b0;
                    m_wvalid_r  <= 1'b0;
                    m_bready_r  <= 1'b0;
                    m_arvalid_r <= 1'b0;
                    m_rready_r  <= 1'b0;
                    s_bvalid_r  <= 2'b00;
                    s_rvalid_r  <= 2'b00;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = s_awready_r;
    assign S_AXI_WREADY  = s_wready_r;
    assign S_AXI_BRESP   = s_bresp_r;
    assign S_AXI_BVALID  = s_bvalid_r;
    assign S_AXI_ARREADY = s_arready_r;
    assign S_AXI_RDATA   = s_rdata_r;
    assign S_AXI_RRESP   = s_rresp_r;
    assign S_AXI_RVALID  = s_rvalid_r;
    assign M_AXI_AWADDR  = m_awaddr_r;
    assign M_AXI_AWPROT  = m_awprot_r;
    assign M_AXI_AWVALID = m_awvalid_r;
    assign M_AXI_WDATA   = m_wdata_r;
    assign M_AXI_WSTRB   = m_wstrb_r;
    assign M_AXI_WVALID  = m_wvalid_r;
    assign M_AXI_BREADY  = m_bready_r;
    assign M_AXI_ARADDR  = m_araddr_r;
    assign M_AXI_ARPROT  = m_arprot_r;
    assign M_AXI_ARVALID = m_arvalid_r;
    assign M_AXI_RREADY  = m_rready_r;

endmodule
